mc_ctrl_hs: RTL and testbench

Multi-cycle MIPS control unit with memory handshakes, for the next-generation datapath. It sequences fetch, decode, execute, memory and write-back states, and stalls on a `mem_rdy` handshake for instruction and data accesses. It also waits on an optional multiply/divide unit, and traps illegal opcodes and memory timeouts into a terminal error state. It drives the same datapath controls as the current controller, plus handshake, mul/div and status signals.

---
 rtl/ctrl_pkg.sv | 113 +++++++++++
 rtl/ctrl_decode.sv | 67 ++++++
 rtl/mc_ctrl_hs.sv | 213 +++++++++++++++++++++
 tb/tb_mc_ctrl_hs.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle and future pipelined MIPS controllers:
// FSM states, MIPS-I opcode/func values, ALU operation codes and mux selects.
package ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch = 4'd0,
        StDcd   = 4'd1,
        StExe   = 4'd2,
        StAluWb = 4'd3,
        StMa    = 4'd4,
        StMr    = 4'd5,
        StMemWb = 4'd6,
        StMw    = 4'd7,
        StBr    = 4'd8,
        StJmp   = 4'd9,
        StJr    = 4'd10,
        StMd    = 4'd11,
        StErr   = 4'd12
    } state_e;

    typedef enum logic [3:0] {
        ClsAluR,
        ClsAluI,
        ClsLoad,
        ClsStore,
        ClsBranch,
        ClsJump,
        ClsJr,
        ClsMulDiv,
        ClsMfHiLo,
        ClsIllegal
    } cls_e;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAddiu = 6'h09;
    localparam logic [5:0] OpAndi  = 6'h0c;
    localparam logic [5:0] OpOri   = 6'h0d;
    localparam logic [5:0] OpXori  = 6'h0e;
    localparam logic [5:0] OpLui   = 6'h0f;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2b;

    localparam logic [5:0] FnSll   = 6'h00;
    localparam logic [5:0] FnSrl   = 6'h02;
    localparam logic [5:0] FnSra   = 6'h03;
    localparam logic [5:0] FnSllv  = 6'h04;
    localparam logic [5:0] FnSrlv  = 6'h06;
    localparam logic [5:0] FnSrav  = 6'h07;
    localparam logic [5:0] FnJr    = 6'h08;
    localparam logic [5:0] FnMfhi  = 6'h10;
    localparam logic [5:0] FnMflo  = 6'h12;
    localparam logic [5:0] FnMult  = 6'h18;
    localparam logic [5:0] FnMultu = 6'h19;
    localparam logic [5:0] FnDiv   = 6'h1a;
    localparam logic [5:0] FnDivu  = 6'h1b;
    localparam logic [5:0] FnAdd   = 6'h20;
    localparam logic [5:0] FnAddu  = 6'h21;
    localparam logic [5:0] FnSub   = 6'h22;
    localparam logic [5:0] FnSubu  = 6'h23;
    localparam logic [5:0] FnAnd   = 6'h24;
    localparam logic [5:0] FnOr    = 6'h25;
    localparam logic [5:0] FnXor   = 6'h26;
    localparam logic [5:0] FnNor   = 6'h27;
    localparam logic [5:0] FnSlt   = 6'h2a;
    localparam logic [5:0] FnSltu  = 6'h2b;

    localparam int unsigned AluCodeW = 5;
    localparam logic [AluCodeW-1:0] AluAdd  = 5'd0;
    localparam logic [AluCodeW-1:0] AluAddu = 5'd1;
    localparam logic [AluCodeW-1:0] AluSub  = 5'd2;
    localparam logic [AluCodeW-1:0] AluSubu = 5'd3;
    localparam logic [AluCodeW-1:0] AluAnd  = 5'd4;
    localparam logic [AluCodeW-1:0] AluOr   = 5'd5;
    localparam logic [AluCodeW-1:0] AluXor  = 5'd6;
    localparam logic [AluCodeW-1:0] AluNor  = 5'd7;
    localparam logic [AluCodeW-1:0] AluSlt  = 5'd8;
    localparam logic [AluCodeW-1:0] AluSltu = 5'd9;
    localparam logic [AluCodeW-1:0] AluSll  = 5'd10;
    localparam logic [AluCodeW-1:0] AluSrl  = 5'd11;
    localparam logic [AluCodeW-1:0] AluSra  = 5'd12;
    localparam logic [AluCodeW-1:0] AluSllv = 5'd13;
    localparam logic [AluCodeW-1:0] AluSrlv = 5'd14;
    localparam logic [AluCodeW-1:0] AluSrav = 5'd15;

    localparam logic [1:0] NpcPc4    = 2'd0;
    localparam logic [1:0] NpcBranch = 2'd1;
    localparam logic [1:0] NpcJump   = 2'd2;
    localparam logic [1:0] NpcReg    = 2'd3;

    localparam logic [1:0] WdAlu  = 2'd0;
    localparam logic [1:0] WdMem  = 2'd1;
    localparam logic [1:0] WdPc   = 2'd2;
    localparam logic [1:0] WdHiLo = 2'd3;

    localparam logic [1:0] RegRd = 2'd0;
    localparam logic [1:0] RegRt = 2'd1;
    localparam logic [1:0] Reg31 = 2'd2;

    localparam logic [1:0] ExtZero  = 2'd0;
    localparam logic [1:0] ExtSign  = 2'd1;
    localparam logic [1:0] ExtUpper = 2'd2;

    // States in which the controller waits on the memory handshake.
    function automatic logic is_wait_state(state_e s);
        return s inside {StFetch, StMr, StMw};
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: op/func to instruction class, ALU operation
// and immediate-extension select. Also used by the pipelined controller.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter bit HAS_MULDIV = 1'b1
) (
    input  logic [5:0]          op,
    input  logic [5:0]          func,
    output cls_e                cls,
    output logic [AluCodeW-1:0] alu_op,
    output logic [1:0]          ext_sel,
    output logic                is_jal,
    output logic                is_bne
);

    always_comb begin
        cls     = ClsIllegal;
        alu_op  = AluAdd;
        ext_sel = ExtSign;
        is_jal  = (op == OpJal);
        is_bne  = (op == OpBne);

        case (op)
            OpRtype: begin
                cls = ClsAluR;
                case (func)
                    FnSll:   alu_op = AluSll;
                    FnSrl:   alu_op = AluSrl;
                    FnSra:   alu_op = AluSra;
                    FnSllv:  alu_op = AluSllv;
                    FnSrlv:  alu_op = AluSrlv;
                    FnSrav:  alu_op = AluSrav;
                    FnAdd:   alu_op = AluAdd;
                    FnAddu:  alu_op = AluAddu;
                    FnSub:   alu_op = AluSub;
                    FnSubu:  alu_op = AluSubu;
                    FnAnd:   alu_op = AluAnd;
                    FnOr:    alu_op = AluOr;
                    FnXor:   alu_op = AluXor;
                    FnNor:   alu_op = AluNor;
                    FnSlt:   alu_op = AluSlt;
                    FnSltu:  alu_op = AluSltu;
                    FnJr:    cls = ClsJr;
                    FnMfhi, FnMflo:
                        cls = HAS_MULDIV ? ClsMfHiLo : ClsIllegal;
                    FnMult, FnMultu, FnDiv, FnDivu:
                        cls = HAS_MULDIV ? ClsMulDiv : ClsIllegal;
                    default: cls = ClsIllegal;
                endcase
            end
            OpAddi:  begin cls = ClsAluI; alu_op = AluAdd;  end
            OpAddiu: begin cls = ClsAluI; alu_op = AluAddu; end
            OpAndi:  begin cls = ClsAluI; alu_op = AluAnd; ext_sel = ExtZero; end
            OpOri:   begin cls = ClsAluI; alu_op = AluOr;  ext_sel = ExtZero; end
            OpXori:  begin cls = ClsAluI; alu_op = AluXor; ext_sel = ExtZero; end
            // lui: the upper-extended immediate is ORed onto $zero.
            OpLui:   begin cls = ClsAluI; alu_op = AluOr;  ext_sel = ExtUpper; end
            OpLw:    cls = ClsLoad;
            OpSw:    cls = ClsStore;
            OpBeq, OpBne: cls = ClsBranch;
            OpJ, OpJal:   cls = ClsJump;
            default: cls = ClsIllegal;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_hs.sv
// Multi-cycle MIPS control FSM with memory ready handshake, mul/div wait,
// memory wait-timeout and sticky illegal-opcode / bus-error flags.
module mc_ctrl_hs
    import ctrl_pkg::*;
#(
    parameter bit          HAS_MULDIV = 1'b1,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned ALUOP_W    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         op,
    input  logic [5:0]         func,
    input  logic               zero,
    input  logic               mem_rdy,
    input  logic               md_busy,
    output logic               mem_req,
    output logic               mem_we,
    output logic               RFWr,
    output logic               DMWr,
    output logic               PCWr,
    output logic               IRWr,
    output logic [1:0]         EXTSel,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         NPCOp,
    output logic [1:0]         RegSel,
    output logic [1:0]         WDSel,
    output logic               BSel,
    output logic               md_start,
    output logic               ill_op,
    output logic               bus_err,
    output logic [3:0]         state_o
);

    state_e               state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 ill_q, ill_d;
    logic                 berr_q, berr_d;
    logic                 wait_hit;

    cls_e                 dec_cls;
    logic [AluCodeW-1:0]  dec_alu;
    logic [1:0]           dec_ext;
    logic                 dec_jal;
    logic                 dec_bne;

    ctrl_decode #(
        .HAS_MULDIV (HAS_MULDIV)
    ) u_decode (
        .op      (op),
        .func    (func),
        .cls     (dec_cls),
        .alu_op  (dec_alu),
        .ext_sel (dec_ext),
        .is_jal  (dec_jal),
        .is_bne  (dec_bne)
    );

    // This wait cycle would be the TIMEOUT-th one without mem_rdy.
    assign wait_hit = (cnt_q == 16'(TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        ill_d    = ill_q;
        berr_d   = berr_q;
        mem_req  = 1'b0;
        RFWr     = 1'b0;
        DMWr     = 1'b0;
        PCWr     = 1'b0;
        IRWr     = 1'b0;
        EXTSel   = ExtZero;
        ALUOp    = '0;
        NPCOp    = NpcPc4;
        RegSel   = RegRd;
        WDSel    = WdAlu;
        BSel     = 1'b0;
        md_start = 1'b0;

        unique case (state_q)
            StFetch: begin
                mem_req = 1'b1;
                if (mem_rdy) begin
                    IRWr    = 1'b1;
                    PCWr    = 1'b1;
                    NPCOp   = NpcPc4;
                    state_d = StDcd;
                end
            end
            StDcd: begin
                EXTSel = dec_ext;
                case (dec_cls)
                    ClsAluR, ClsAluI, ClsMulDiv, ClsMfHiLo: state_d = StExe;
                    ClsLoad, ClsStore: state_d = StMa;
                    ClsBranch:         state_d = StBr;
                    ClsJump:           state_d = StJmp;
                    ClsJr:             state_d = StJr;
                    default: begin
                        state_d = StErr;
                        ill_d   = 1'b1;
                    end
                endcase
            end
            StExe: begin
                BSel  = (dec_cls == ClsAluI);
                ALUOp = ALUOP_W'(dec_alu);
                if (dec_cls == ClsMulDiv) begin
                    md_start = 1'b1;
                    state_d  = StMd;
                end else begin
                    state_d = StAluWb;
                end
            end
            StAluWb: begin
                RFWr    = 1'b1;
                RegSel  = (dec_cls == ClsAluI) ? RegRt : RegRd;
                WDSel   = (dec_cls == ClsMfHiLo) ? WdHiLo : WdAlu;
                state_d = StFetch;
            end
            StMa: begin
                BSel    = 1'b1;
                ALUOp   = ALUOP_W'(AluAddu);
                state_d = (dec_cls == ClsLoad) ? StMr : StMw;
            end
            StMr: begin
                mem_req = 1'b1;
                if (mem_rdy) state_d = StMemWb;
            end
            StMemWb: begin
                RFWr    = 1'b1;
                RegSel  = RegRt;
                WDSel   = WdMem;
                state_d = StFetch;
            end
            StMw: begin
                mem_req = 1'b1;
                DMWr    = 1'b1;
                if (mem_rdy) state_d = StFetch;
            end
            StBr: begin
                ALUOp   = ALUOP_W'(AluSubu);
                NPCOp   = NpcBranch;
                PCWr    = dec_bne ? ~zero : zero;
                state_d = StFetch;
            end
            StJmp: begin
                PCWr  = 1'b1;
                NPCOp = NpcJump;
                if (dec_jal) begin
                    RFWr   = 1'b1;
                    RegSel = Reg31;
                    WDSel  = WdPc;
                end
                state_d = StFetch;
            end
            StJr: begin
                PCWr    = 1'b1;
                NPCOp   = NpcReg;
                state_d = StFetch;
            end
            StMd: begin
                if (!md_busy) state_d = StFetch;
            end
            StErr: state_d = StErr;
            default: state_d = StErr;
        endcase

        if (is_wait_state(state_q) && !mem_rdy) begin
            if (wait_hit) begin
                state_d = StErr;
                berr_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end

        // Reset kills every strobe in the same cycle, including the fetch request.
        if (rst) begin
            mem_req  = 1'b0;
            RFWr     = 1'b0;
            DMWr     = 1'b0;
            PCWr     = 1'b0;
            IRWr     = 1'b0;
            EXTSel   = '0;
            ALUOp    = '0;
            NPCOp    = '0;
            RegSel   = '0;
            WDSel    = '0;
            BSel     = 1'b0;
            md_start = 1'b0;
        end
    end

    assign mem_we  = DMWr;
    assign ill_op  = ill_q;
    assign bus_err = berr_q;
    assign state_o = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
            cnt_q   <= '0;
            ill_q   <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
            berr_q  <= berr_d;
        end
    end

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// Scoreboard bench for mc_ctrl_hs: directed instruction sequences push per-cycle
// expected outputs; a negedge monitor pops and compares them against the DUT.
module tb_mc_ctrl_hs;
    import ctrl_pkg::*;

    typedef struct packed {
        state_e     st;
        logic       mem_req;
        logic       mem_we;
        logic       rfwr;
        logic       dmwr;
        logic       pcwr;
        logic       irwr;
        logic [1:0] ext;
        logic [4:0] alu;
        logic [1:0] npc;
        logic [1:0] regsel;
        logic [1:0] wdsel;
        logic       bsel;
        logic       md_start;
        logic       ill;
        logic       berr;
    } vec_t;

    // b_mode: 0 = B follows the A state/ill_op, 1 = B parked in ERR with ill_op, 2 = skip
    typedef struct {
        string nm;
        vec_t  e;
        int    b_mode;
    } item_t;

    logic clk = 1'b0;
    logic rst, zero, mem_rdy, md_busy;
    logic [5:0] op, func;

    logic a_mem_req, a_mem_we, a_rfwr, a_dmwr, a_pcwr, a_irwr, a_bsel, a_md_start, a_ill, a_berr;
    logic [1:0] a_ext, a_npc, a_regsel, a_wdsel;
    logic [4:0] a_alu;
    logic [3:0] a_state;

    logic b_mem_req, b_mem_we, b_rfwr, b_dmwr, b_pcwr, b_irwr, b_bsel, b_md_start, b_ill, b_berr;
    logic [1:0] b_ext, b_npc, b_regsel, b_wdsel;
    logic [4:0] b_alu;
    logic [3:0] b_state;

    item_t q[$];
    int    total = 0;
    int    bad = 0;
    int    b_mode;
    bit    stim_done = 1'b0;
    bit    mon_done = 1'b0;
    logic  ill_s, berr_s;
    vec_t  e;

    always #5 clk = ~clk;

    mc_ctrl_hs #(.HAS_MULDIV(1'b1), .TIMEOUT(4), .ALUOP_W(5)) u_dut_a (
        .clk(clk), .rst(rst), .op(op), .func(func), .zero(zero), .mem_rdy(mem_rdy),
        .md_busy(md_busy), .mem_req(a_mem_req), .mem_we(a_mem_we), .RFWr(a_rfwr),
        .DMWr(a_dmwr), .PCWr(a_pcwr), .IRWr(a_irwr), .EXTSel(a_ext), .ALUOp(a_alu),
        .NPCOp(a_npc), .RegSel(a_regsel), .WDSel(a_wdsel), .BSel(a_bsel),
        .md_start(a_md_start), .ill_op(a_ill), .bus_err(a_berr), .state_o(a_state)
    );

    mc_ctrl_hs #(.HAS_MULDIV(1'b0), .TIMEOUT(4), .ALUOP_W(5)) u_dut_b (
        .clk(clk), .rst(rst), .op(op), .func(func), .zero(zero), .mem_rdy(mem_rdy),
        .md_busy(md_busy), .mem_req(b_mem_req), .mem_we(b_mem_we), .RFWr(b_rfwr),
        .DMWr(b_dmwr), .PCWr(b_pcwr), .IRWr(b_irwr), .EXTSel(b_ext), .ALUOp(b_alu),
        .NPCOp(b_npc), .RegSel(b_regsel), .WDSel(b_wdsel), .BSel(b_bsel),
        .md_start(b_md_start), .ill_op(b_ill), .bus_err(b_berr), .state_o(b_state)
    );

    // Monitor: one expected vector per clock, sampled mid-cycle.
    item_t it;
    vec_t  act;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            it = q.pop_front();
            act.st = state_e'(a_state);
            act.mem_req = a_mem_req;  act.mem_we = a_mem_we;  act.rfwr = a_rfwr;
            act.dmwr = a_dmwr;        act.pcwr = a_pcwr;      act.irwr = a_irwr;
            act.ext = a_ext;          act.alu = a_alu;        act.npc = a_npc;
            act.regsel = a_regsel;    act.wdsel = a_wdsel;    act.bsel = a_bsel;
            act.md_start = a_md_start; act.ill = a_ill;       act.berr = a_berr;
            total++;
            if (act !== it.e) begin
                bad++;
                $display("FAIL %s: got st=%0d vec=%h, want st=%0d vec=%h",
                         it.nm, a_state, act, it.e.st, it.e);
            end
            if (it.b_mode != 2) begin
                total++;
                if (it.b_mode == 1) begin
                    if (b_state !== 4'(StErr) || b_ill !== 1'b1) begin
                        bad++;
                        $display("FAIL %s_nomd: got st=%0d ill=%b, want st=%0d ill=1",
                                 it.nm, b_state, b_ill, StErr);
                    end
                end else if (b_state !== 4'(it.e.st) || b_ill !== it.e.ill) begin
                    bad++;
                    $display("FAIL %s_nomd: got st=%0d ill=%b, want st=%0d ill=%b",
                             it.nm, b_state, b_ill, it.e.st, it.e.ill);
                end
            end
        end else if (stim_done) begin
            mon_done = 1'b1;
        end
    end

    function automatic vec_t v(state_e s);
        vec_t r = '0;
        r.st   = s;
        r.ill  = ill_s;
        r.berr = berr_s;
        return r;
    endfunction

    task automatic cyc(input string nm, input vec_t ex);
        item_t i;
        i.nm = nm;
        i.e = ex;
        i.b_mode = b_mode;
        q.push_back(i);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_ok(input string nm);
        vec_t x;
        mem_rdy = 1'b1;
        x = v(StFetch);
        x.mem_req = 1'b1; x.irwr = 1'b1; x.pcwr = 1'b1;
        cyc({nm, "_fetch"}, x);
    endtask

    task automatic dcd(input string nm, input logic [1:0] ext);
        vec_t x;
        x = v(StDcd);
        x.ext = ext;
        cyc({nm, "_dcd"}, x);
    endtask

    initial begin
        rst = 1'b1; op = '0; func = '0; zero = 1'b0; mem_rdy = 1'b1; md_busy = 1'b0;
        b_mode = 0; ill_s = 1'b0; berr_s = 1'b0;
        @(posedge clk);
        #1;
        cyc("reset0", v(StFetch));
        cyc("reset1", v(StFetch));
        rst = 1'b0;

        // addu
        op = OpRtype; func = FnAddu;
        fetch_ok("addu"); dcd("addu", ExtSign);
        e = v(StExe); e.alu = AluAddu; cyc("addu_exe", e);
        e = v(StAluWb); e.rfwr = 1'b1; cyc("addu_wb", e);

        // lw with three wait states in MR
        op = OpLw;
        fetch_ok("lw"); dcd("lw", ExtSign);
        e = v(StMa); e.bsel = 1'b1; e.alu = AluAddu; cyc("lw_ma", e);
        mem_rdy = 1'b0;
        e = v(StMr); e.mem_req = 1'b1;
        cyc("lw_mr_w0", e); cyc("lw_mr_w1", e); cyc("lw_mr_w2", e);
        mem_rdy = 1'b1; cyc("lw_mr_rdy", e);
        e = v(StMemWb); e.rfwr = 1'b1; e.regsel = RegRt; e.wdsel = WdMem; cyc("lw_memwb", e);

        // bne taken / not taken, beq taken
        op = OpBne; zero = 1'b0;
        fetch_ok("bne0"); dcd("bne0", ExtSign);
        e = v(StBr); e.alu = AluSubu; e.npc = NpcBranch; e.pcwr = 1'b1; cyc("bne0_br", e);
        zero = 1'b1;
        fetch_ok("bne1"); dcd("bne1", ExtSign);
        e = v(StBr); e.alu = AluSubu; e.npc = NpcBranch; cyc("bne1_br", e);
        op = OpBeq;
        fetch_ok("beq1"); dcd("beq1", ExtSign);
        e = v(StBr); e.alu = AluSubu; e.npc = NpcBranch; e.pcwr = 1'b1; cyc("beq1_br", e);
        zero = 1'b0;

        // ori: zero-extend, immediate operand, rt destination
        op = OpOri;
        fetch_ok("ori"); dcd("ori", ExtZero);
        e = v(StExe); e.bsel = 1'b1; e.alu = AluOr; cyc("ori_exe", e);
        e = v(StAluWb); e.rfwr = 1'b1; e.regsel = RegRt; cyc("ori_wb", e);

        // jal and jr
        op = OpJal;
        fetch_ok("jal"); dcd("jal", ExtSign);
        e = v(StJmp); e.pcwr = 1'b1; e.npc = NpcJump; e.rfwr = 1'b1;
        e.regsel = Reg31; e.wdsel = WdPc; cyc("jal_jmp", e);
        op = OpRtype; func = FnJr;
        fetch_ok("jr"); dcd("jr", ExtSign);
        e = v(StJr); e.pcwr = 1'b1; e.npc = NpcReg; cyc("jr_jr", e);

        // sw: mem_rdy lands on the 4th wait cycle, exactly at TIMEOUT, and wins
        op = OpSw;
        fetch_ok("sw"); dcd("sw", ExtSign);
        e = v(StMa); e.bsel = 1'b1; e.alu = AluAddu; cyc("sw_ma", e);
        mem_rdy = 1'b0;
        e = v(StMw); e.mem_req = 1'b1; e.mem_we = 1'b1; e.dmwr = 1'b1;
        cyc("sw_mw_w0", e); cyc("sw_mw_w1", e); cyc("sw_mw_w2", e);
        mem_rdy = 1'b1; cyc("sw_mw_rdy_at_limit", e);

        // mult: A runs the mul/div path, B (no mul/div) traps
        op = OpRtype; func = FnMult;
        fetch_ok("mult"); dcd("mult", ExtSign);
        b_mode = 1;
        e = v(StExe); e.md_start = 1'b1; cyc("mult_exe", e);
        md_busy = 1'b1;
        e = v(StMd);
        for (int i = 0; i < 5; i++) cyc($sformatf("mult_md_busy%0d", i), e);
        md_busy = 1'b0; cyc("mult_md_done", e);

        // mfhi on A only
        func = FnMfhi;
        fetch_ok("mfhi"); dcd("mfhi", ExtSign);
        e = v(StExe); cyc("mfhi_exe", e);
        e = v(StAluWb); e.rfwr = 1'b1; e.wdsel = WdHiLo; cyc("mfhi_wb", e);

        // fetch timeout: four wait cycles then terminal ERR
        func = FnAddu; mem_rdy = 1'b0;
        e = v(StFetch); e.mem_req = 1'b1;
        for (int i = 0; i < 4; i++) cyc($sformatf("to_fetch_w%0d", i), e);
        berr_s = 1'b1;
        cyc("to_err0", v(StErr));
        cyc("to_err1", v(StErr));
        mem_rdy = 1'b1;
        cyc("to_err_rdy_ignored", v(StErr));

        // reset pulse clears both flags on both instances
        rst = 1'b1; b_mode = 0; berr_s = 1'b0;
        cyc("rst_pulse", v(StFetch));
        rst = 1'b0;

        // reset in MW kills DMWr in the same cycle
        op = OpSw;
        fetch_ok("swr"); dcd("swr", ExtSign);
        e = v(StMa); e.bsel = 1'b1; e.alu = AluAddu; cyc("swr_ma", e);
        mem_rdy = 1'b0;
        e = v(StMw); e.mem_req = 1'b1; e.mem_we = 1'b1; e.dmwr = 1'b1; cyc("swr_mw", e);
        rst = 1'b1;
        cyc("swr_rst", v(StFetch));
        rst = 1'b0;
        e = v(StFetch); e.mem_req = 1'b1; cyc("swr_refetch_wait", e);
        fetch_ok("swr_refetch");

        stim_done = 1'b1;
        for (int i = 0; i < 10 && !mon_done; i++) @(posedge clk);
        if (!mon_done) begin
            $display("FAIL drain: got %0d pending items, want 0", q.size());
            $fatal(1, "scoreboard did not drain");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
